// File: rtl/flag_stack_unit.sv
// Flag register for the RAT CPU: live C/Z/I flags plus a LIFO shadow stack
// that saves {C,Z} on interrupt entry and restores them on return.
module flag_stack_unit #(
    parameter  int SHADOW_DEPTH = 4,
    localparam int DW           = $clog2(SHADOW_DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          ALU_C,
    input  logic          ALU_Z,
    input  logic          FLG_C_LD,
    input  logic          FLG_Z_LD,
    input  logic          FLG_C_SET,
    input  logic          FLG_C_CLR,
    input  logic          I_SET,
    input  logic          I_CLR,
    input  logic          FLG_PUSH,
    input  logic          FLG_POP,
    input  logic          RETI_IE,
    input  logic          ERR_CLR,
    output logic          C_FLAG,
    output logic          Z_FLAG,
    output logic          I_FLAG,
    output logic [DW-1:0] STK_DEPTH,
    output logic          STK_FULL,
    output logic          STK_EMPTY,
    output logic          STK_ERR
);

    logic          c_q, c_d;
    logic          z_q, z_d;
    logic          i_q, i_d;
    logic          err_q, err_d;
    logic [DW-1:0] depth_q, depth_d;
    logic [1:0]    stack_q [SHADOW_DEPTH];

    logic          full, empty;
    logic          push_only, pop_only, push_pop;
    logic          push_ok, pop_ok, err_now;
    logic [1:0]    top_pair;

    always_comb begin
        full      = (depth_q == DW'(SHADOW_DEPTH));
        empty     = (depth_q == '0);
        push_only = FLG_PUSH & ~FLG_POP;
        pop_only  = FLG_POP & ~FLG_PUSH;
        push_pop  = FLG_PUSH & FLG_POP;
        push_ok   = push_only & ~full;
        pop_ok    = pop_only & ~empty;
        err_now   = (push_only & full) | (pop_only & empty) | push_pop;

        // Compare-based select keeps the index width independent of the array size.
        top_pair = '0;
        for (int unsigned i = 0; i < SHADOW_DEPTH; i++) begin
            if (depth_q == DW'(i + 1)) top_pair = stack_q[i];
        end
    end

    always_comb begin
        c_d     = c_q;
        z_d     = z_q;
        i_d     = i_q;
        err_d   = err_q;
        depth_d = depth_q;

        if (pop_ok)         c_d = top_pair[1];
        else if (FLG_C_SET) c_d = 1'b1;
        else if (FLG_C_CLR) c_d = 1'b0;
        else if (FLG_C_LD)  c_d = ALU_C;

        if (pop_ok)         z_d = top_pair[0];
        else if (FLG_Z_LD)  z_d = ALU_Z;

        if (FLG_PUSH)       i_d = 1'b0;
        else if (FLG_POP)   i_d = RETI_IE;
        else if (I_SET)     i_d = 1'b1;
        else if (I_CLR)     i_d = 1'b0;

        if (push_ok)        depth_d = depth_q + DW'(1);
        else if (pop_ok)    depth_d = depth_q - DW'(1);

        if (err_now)        err_d = 1'b1;
        else if (ERR_CLR)   err_d = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            i_q     <= 1'b0;
            err_q   <= 1'b0;
            depth_q <= '0;
        end else begin
            c_q     <= c_d;
            z_q     <= z_d;
            i_q     <= i_d;
            err_q   <= err_d;
            depth_q <= depth_d;
        end
    end

    // Stack storage is not reset; entries above the depth are never read.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            for (int unsigned i = 0; i < SHADOW_DEPTH; i++) begin
                if (depth_q == DW'(i)) stack_q[i] <= {c_q, z_q};
            end
        end
    end

    assign C_FLAG    = c_q;
    assign Z_FLAG    = z_q;
    assign I_FLAG    = i_q;
    assign STK_DEPTH = depth_q;
    assign STK_FULL  = full;
    assign STK_EMPTY = empty;
    assign STK_ERR   = err_q;

endmodule

// File: tb/tb_flag_stack_unit.sv
// Self-checking bench for flag_stack_unit: directed scenarios plus random
// strobes compared against a queue-based reference model.
module tb_flag_stack_unit;

    localparam int DEPTH = 4;
    localparam int DW    = $clog2(DEPTH + 1);

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          ALU_C, ALU_Z, FLG_C_LD, FLG_Z_LD, FLG_C_SET, FLG_C_CLR;
    logic          I_SET, I_CLR, FLG_PUSH, FLG_POP, RETI_IE, ERR_CLR;
    logic          C_FLAG, Z_FLAG, I_FLAG, STK_FULL, STK_EMPTY, STK_ERR;
    logic [DW-1:0] STK_DEPTH;

    int checks = 0;
    int errors = 0;

    logic       m_c, m_z, m_i, m_err;
    logic [1:0] m_stk [$];

    flag_stack_unit #(.SHADOW_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .ALU_C(ALU_C), .ALU_Z(ALU_Z),
        .FLG_C_LD(FLG_C_LD), .FLG_Z_LD(FLG_Z_LD), .FLG_C_SET(FLG_C_SET),
        .FLG_C_CLR(FLG_C_CLR), .I_SET(I_SET), .I_CLR(I_CLR),
        .FLG_PUSH(FLG_PUSH), .FLG_POP(FLG_POP), .RETI_IE(RETI_IE),
        .ERR_CLR(ERR_CLR), .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .I_FLAG(I_FLAG),
        .STK_DEPTH(STK_DEPTH), .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY),
        .STK_ERR(STK_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic clr_in();
        ALU_C = 0; ALU_Z = 0; FLG_C_LD = 0; FLG_Z_LD = 0; FLG_C_SET = 0;
        FLG_C_CLR = 0; I_SET = 0; I_CLR = 0; FLG_PUSH = 0; FLG_POP = 0;
        RETI_IE = 0; ERR_CLR = 0;
    endtask

    task automatic model_reset();
        m_c = 0; m_z = 0; m_i = 0; m_err = 0;
        m_stk.delete();
    endtask

    // Advance the reference model by the strobes currently driven, clock once,
    // then sample 1 ns after the edge and release the strobes.
    task automatic cyc();
        logic nc, nz, ni, e;
        logic [1:0] p;
        nc = m_c; nz = m_z; ni = m_i; e = 0;
        if (FLG_C_SET) nc = 1; else if (FLG_C_CLR) nc = 0; else if (FLG_C_LD) nc = ALU_C;
        if (FLG_Z_LD) nz = ALU_Z;
        if (I_SET) ni = 1; else if (I_CLR) ni = 0;
        if (FLG_PUSH && FLG_POP) begin
            e = 1; ni = 0;
        end else if (FLG_PUSH) begin
            ni = 0;
            if (m_stk.size() == DEPTH) e = 1;
            else m_stk.push_back({m_c, m_z});
        end else if (FLG_POP) begin
            ni = RETI_IE;
            if (m_stk.size() == 0) e = 1;
            else begin
                p = m_stk.pop_back();
                nc = p[1]; nz = p[0];
            end
        end
        m_c = nc; m_z = nz; m_i = ni;
        m_err = e ? 1'b1 : (ERR_CLR ? 1'b0 : m_err);
        @(posedge CLK);
        #1;
        clr_in();
    endtask

    function automatic logic [DW+5:0] model_vec();
        return {m_c, m_z, m_i, DW'(m_stk.size()), m_stk.size() == DEPTH,
                m_stk.size() == 0, m_err};
    endfunction

    task automatic test_reset();
        FLG_C_SET = 1; FLG_Z_LD = 1; ALU_Z = 1; FLG_PUSH = 1; cyc();
        FLG_PUSH = 1; cyc();
        I_SET = 1; cyc();
        checks++;
        if ({C_FLAG, Z_FLAG, I_FLAG, STK_DEPTH} !== {3'b111, DW'(2)}) begin
            errors++;
            $display("FAIL reset_setup got CZI=%b%b%b depth=%0d exp CZI=111 depth=2",
                     C_FLAG, Z_FLAG, I_FLAG, STK_DEPTH);
        end
        #2 RST_N = 0;
        #1;
        model_reset();
        checks++;
        if ({C_FLAG, Z_FLAG, I_FLAG, STK_DEPTH, STK_EMPTY, STK_FULL, STK_ERR}
            !== {3'b000, DW'(0), 3'b100}) begin
            errors++;
            $display("FAIL async_reset got CZI=%b%b%b depth=%0d e/f/err=%b%b%b exp 000 0 100",
                     C_FLAG, Z_FLAG, I_FLAG, STK_DEPTH, STK_EMPTY, STK_FULL, STK_ERR);
        end
        @(posedge CLK); #1;
        RST_N = 1;
        FLG_C_SET = 1; cyc();
        checks++;
        if (C_FLAG !== 1'b1 || STK_DEPTH !== DW'(0)) begin
            errors++;
            $display("FAIL first_edge_after_reset got C=%b depth=%0d exp C=1 depth=0",
                     C_FLAG, STK_DEPTH);
        end
    endtask

    task automatic test_priority();
        FLG_C_SET = 1; FLG_C_CLR = 1; FLG_C_LD = 1; ALU_C = 0; cyc();
        checks++;
        if (C_FLAG !== 1'b1) begin
            errors++; $display("FAIL prio_set got C=%b exp 1", C_FLAG);
        end
        FLG_C_CLR = 1; FLG_C_LD = 1; ALU_C = 1; cyc();
        checks++;
        if (C_FLAG !== 1'b0) begin
            errors++; $display("FAIL prio_clr got C=%b exp 0", C_FLAG);
        end
        FLG_Z_LD = 1; ALU_Z = 1; cyc();
        checks++;
        if (Z_FLAG !== 1'b1) begin
            errors++; $display("FAIL prio_zld got Z=%b exp 1", Z_FLAG);
        end
        I_SET = 1; I_CLR = 1; cyc();
        checks++;
        if (I_FLAG !== 1'b1) begin
            errors++; $display("FAIL prio_iset got I=%b exp 1", I_FLAG);
        end
    endtask

    task automatic test_nested();
        FLG_C_SET = 1; FLG_Z_LD = 1; ALU_Z = 0; I_SET = 1; cyc();
        FLG_PUSH = 1; cyc();
        FLG_C_LD = 1; ALU_C = 0; FLG_Z_LD = 1; ALU_Z = 1; cyc();
        FLG_PUSH = 1; cyc();
        FLG_C_LD = 1; ALU_C = 1; FLG_Z_LD = 1; ALU_Z = 1; cyc();
        FLG_POP = 1; RETI_IE = 0; cyc();
        checks++;
        if ({C_FLAG, Z_FLAG, I_FLAG, STK_DEPTH} !== {3'b010, DW'(1)}) begin
            errors++;
            $display("FAIL nested_pop1 got CZI=%b%b%b depth=%0d exp 010 depth=1",
                     C_FLAG, Z_FLAG, I_FLAG, STK_DEPTH);
        end
        FLG_POP = 1; RETI_IE = 1; cyc();
        checks++;
        if ({C_FLAG, Z_FLAG, I_FLAG, STK_DEPTH, STK_EMPTY} !== {3'b101, DW'(0), 1'b1}) begin
            errors++;
            $display("FAIL nested_pop2 got CZI=%b%b%b depth=%0d empty=%b exp 101 0 1",
                     C_FLAG, Z_FLAG, I_FLAG, STK_DEPTH, STK_EMPTY);
        end
    endtask

    task automatic test_overflow();
        logic [1:0] pr [6];
        for (int i = 0; i < 6; i++) pr[i] = 2'($urandom_range(0, 3));
        FLG_C_LD = 1; FLG_Z_LD = 1; {ALU_C, ALU_Z} = pr[0]; cyc();
        for (int i = 0; i < 5; i++) begin
            FLG_PUSH = 1; FLG_C_LD = 1; FLG_Z_LD = 1; {ALU_C, ALU_Z} = pr[i+1]; cyc();
        end
        checks++;
        if ({STK_DEPTH, STK_FULL, STK_ERR, I_FLAG} !== {DW'(4), 3'b110}) begin
            errors++;
            $display("FAIL overflow got depth=%0d full=%b err=%b I=%b exp 4 1 1 0",
                     STK_DEPTH, STK_FULL, STK_ERR, I_FLAG);
        end
        for (int k = 0; k < 4; k++) begin
            FLG_POP = 1; RETI_IE = 1'($urandom_range(0, 1)); cyc();
            checks++;
            if ({C_FLAG, Z_FLAG, STK_DEPTH} !== {pr[3-k], DW'(3 - k)}) begin
                errors++;
                $display("FAIL overflow_pop%0d got CZ=%b%b depth=%0d exp CZ=%b depth=%0d",
                         k, C_FLAG, Z_FLAG, STK_DEPTH, pr[3-k], 3 - k);
            end
        end
    endtask

    task automatic test_underflow_illegal();
        ERR_CLR = 1; FLG_C_CLR = 1; cyc();
        FLG_POP = 1; FLG_C_LD = 1; ALU_C = 1; cyc();
        checks++;
        if ({C_FLAG, STK_DEPTH, STK_ERR} !== {1'b1, DW'(0), 1'b1}) begin
            errors++;
            $display("FAIL underflow got C=%b depth=%0d err=%b exp 1 0 1",
                     C_FLAG, STK_DEPTH, STK_ERR);
        end
        ERR_CLR = 1; cyc();
        checks++;
        if (STK_ERR !== 1'b0) begin
            errors++; $display("FAIL err_clr got err=%b exp 0", STK_ERR);
        end
        FLG_PUSH = 1; cyc();
        I_SET = 1; cyc();
        FLG_PUSH = 1; FLG_POP = 1; RETI_IE = 1; cyc();
        checks++;
        if ({STK_DEPTH, I_FLAG, STK_ERR} !== {DW'(1), 2'b01}) begin
            errors++;
            $display("FAIL push_pop_illegal got depth=%0d I=%b err=%b exp 1 0 1",
                     STK_DEPTH, I_FLAG, STK_ERR);
        end
        ERR_CLR = 1; FLG_PUSH = 1; cyc();
        checks++;
        if (STK_ERR !== 1'b0 || STK_DEPTH !== DW'(2)) begin
            errors++;
            $display("FAIL err_clr_push got err=%b depth=%0d exp 0 2", STK_ERR, STK_DEPTH);
        end
    endtask

    task automatic test_push_load();
        FLG_C_SET = 1; cyc();
        FLG_PUSH = 1; FLG_C_LD = 1; ALU_C = 0; cyc();
        checks++;
        if (C_FLAG !== 1'b0) begin
            errors++; $display("FAIL push_load_live got C=%b exp 0", C_FLAG);
        end
        FLG_POP = 1; RETI_IE = 1; cyc();
        checks++;
        if (C_FLAG !== 1'b1 || STK_DEPTH !== DW'(2)) begin
            errors++;
            $display("FAIL push_load_restore got C=%b depth=%0d exp 1 2", C_FLAG, STK_DEPTH);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] saved;
        for (int n = 0; n < 20; n++) begin
            if (m_stk.size() == DEPTH) begin
                FLG_POP = 1; cyc();
            end
            saved = {m_c, m_z};
            FLG_PUSH = 1; FLG_C_LD = 1; FLG_Z_LD = 1;
            ALU_C = 1'($urandom_range(0, 1)); ALU_Z = 1'($urandom_range(0, 1)); cyc();
            FLG_POP = 1; RETI_IE = 1'($urandom_range(0, 1)); cyc();
            checks++;
            if ({C_FLAG, Z_FLAG} !== saved) begin
                errors++;
                $display("FAIL b2b_pop iter=%0d got CZ=%b%b exp %b", n, C_FLAG, Z_FLAG, saved);
            end
        end
    endtask

    task automatic test_random();
        logic [DW+5:0] got;
        for (int n = 0; n < 400; n++) begin
            FLG_PUSH  = ($urandom_range(0, 3) == 0);
            FLG_POP   = ($urandom_range(0, 3) == 0);
            FLG_C_LD  = ($urandom_range(0, 2) == 0);
            FLG_Z_LD  = ($urandom_range(0, 2) == 0);
            FLG_C_SET = ($urandom_range(0, 5) == 0);
            FLG_C_CLR = ($urandom_range(0, 5) == 0);
            I_SET     = ($urandom_range(0, 4) == 0);
            I_CLR     = ($urandom_range(0, 4) == 0);
            ERR_CLR   = ($urandom_range(0, 3) == 0);
            ALU_C     = 1'($urandom_range(0, 1));
            ALU_Z     = 1'($urandom_range(0, 1));
            RETI_IE   = 1'($urandom_range(0, 1));
            cyc();
            got = {C_FLAG, Z_FLAG, I_FLAG, STK_DEPTH, STK_FULL, STK_EMPTY, STK_ERR};
            checks++;
            if (got !== model_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got CZI/depth/full/empty/err=%b exp %b",
                         n, got, model_vec());
            end
        end
    endtask

    initial begin
        clr_in();
        model_reset();
        RST_N = 0;
        #12;
        checks++;
        if ({C_FLAG, Z_FLAG, I_FLAG, STK_DEPTH, STK_EMPTY, STK_FULL, STK_ERR}
            !== {3'b000, DW'(0), 3'b100}) begin
            errors++;
            $display("FAIL power_on_reset got CZI=%b%b%b depth=%0d e/f/err=%b%b%b exp 000 0 100",
                     C_FLAG, Z_FLAG, I_FLAG, STK_DEPTH, STK_EMPTY, STK_FULL, STK_ERR);
        end
        @(posedge CLK); #1;
        RST_N = 1;
        test_reset();
        test_priority();
        test_nested();
        test_overflow();
        test_underflow_illegal();
        test_push_load();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
